// File: rtl/ofm_stream_checker.sv
// On-chip OFM result checker: sweeps an OFM address window, reads the OFM and golden
// RAMs in lockstep and compares them lane by lane, reporting count and first mismatch.
module ofm_stream_checker #(
   parameter int DATA_WIDTH   = 64,
   parameter int LANES        = 16,
   parameter int OFM_RAM_SIZE = 2378675,
   parameter int GLD_RAM_SIZE = 144,
   parameter int RD_LATENCY   = 1,
   parameter int CNT_W        = 24,
   localparam int ADDR_W      = $clog2(OFM_RAM_SIZE),
   localparam int GADDR_W     = $clog2(GLD_RAM_SIZE),
   localparam int BUS_W       = LANES * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [CNT_W-1:0]      num_beats,
   input  logic                  stop_on_first,
   output logic                  ofm_rd_en,
   output logic [ADDR_W-1:0]     ofm_rd_addr,
   input  logic [BUS_W-1:0]      ofm_rd_data,
   output logic                  gld_rd_en,
   output logic [GADDR_W-1:0]    gld_rd_addr,
   input  logic [BUS_W-1:0]      gld_rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [CNT_W-1:0]      mismatch_count,
   output logic                  first_err_valid,
   output logic [CNT_W-1:0]      first_err_idx,
   output logic [DATA_WIDTH-1:0] first_err_ofm,
   output logic [DATA_WIDTH-1:0] first_err_gld
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

   state_t                  state, state_next;
   logic [ADDR_W-1:0]       addr_q;
   logic [GADDR_W-1:0]      gaddr_q;
   logic [CNT_W-1:0]        issue_cnt;
   logic [CNT_W-1:0]        num_q;
   logic                    stop_q;
   logic [RD_LATENCY-1:0]   vpipe;
   logic [CNT_W-1:0]        cmp_beat;

   logic                    issue;
   logic                    cmp_valid;
   logic                    any_miss;
   logic                    abort;
   logic [CNT_W:0]          pop;
   logic [CNT_W:0]          sum;
   logic [CNT_W-1:0]        first_lane;
   logic [CNT_W-1:0]        err_idx;
   logic [DATA_WIDTH-1:0]   err_ofm;
   logic [DATA_WIDTH-1:0]   err_gld;

   assign issue       = (state == ISSUE);
   assign ofm_rd_en   = issue;
   assign gld_rd_en   = issue;
   assign ofm_rd_addr = addr_q;
   assign gld_rd_addr = gaddr_q;
   assign busy        = (state == ISSUE) || (state == DRAIN);
   assign done        = (state == FINISH);
   assign cmp_valid   = vpipe[RD_LATENCY-1];
   assign abort       = cmp_valid && any_miss && stop_q;
   assign sum         = {1'b0, mismatch_count} + pop;
   assign err_idx     = cmp_beat * CNT_W'(LANES) + first_lane;

   // Scanning from the top lane down leaves the lowest failing lane as the reported one.
   always_comb begin
      any_miss   = 1'b0;
      pop        = '0;
      first_lane = '0;
      err_ofm    = '0;
      err_gld    = '0;
      for (int l = LANES - 1; l >= 0; l--) begin
         if (ofm_rd_data[l*DATA_WIDTH +: DATA_WIDTH] != gld_rd_data[l*DATA_WIDTH +: DATA_WIDTH]) begin
            any_miss   = 1'b1;
            pop        = pop + (CNT_W+1)'(1);
            first_lane = CNT_W'(l);
            err_ofm    = ofm_rd_data[l*DATA_WIDTH +: DATA_WIDTH];
            err_gld    = gld_rd_data[l*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // DRAIN only exits once nothing is in flight, so the counters are final in FINISH.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) state_next = (num_beats == '0) ? FINISH : ISSUE;
         end
         ISSUE: begin
            if (abort || (issue_cnt == num_q - CNT_W'(1))) state_next = DRAIN;
         end
         DRAIN: begin
            if (!abort && (vpipe == '0)) state_next = FINISH;
         end
         FINISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         addr_q          <= '0;
         gaddr_q         <= '0;
         issue_cnt       <= '0;
         num_q           <= '0;
         stop_q          <= 1'b0;
         vpipe           <= '0;
         cmp_beat        <= '0;
         pass            <= 1'b0;
         mismatch_count  <= '0;
         first_err_valid <= 1'b0;
         first_err_idx   <= '0;
         first_err_ofm   <= '0;
         first_err_gld   <= '0;
      end else begin
         state <= state_next;

         // An abort discards every beat still in flight.
         if (abort) begin
            vpipe <= '0;
         end else begin
            vpipe[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) vpipe[i] <= vpipe[i-1];
         end

         if (state == IDLE && start) begin
            addr_q          <= base_addr;
            gaddr_q         <= '0;
            issue_cnt       <= '0;
            num_q           <= num_beats;
            stop_q          <= stop_on_first;
            cmp_beat        <= '0;
            pass            <= 1'b0;
            mismatch_count  <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_ofm   <= '0;
            first_err_gld   <= '0;
         end

         if (issue) begin
            addr_q    <= addr_q + ADDR_W'(1);
            gaddr_q   <= gaddr_q + GADDR_W'(1);
            issue_cnt <= issue_cnt + CNT_W'(1);
         end

         if (cmp_valid) begin
            cmp_beat <= cmp_beat + CNT_W'(1);
            if (any_miss) begin
               mismatch_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
               if (!first_err_valid) begin
                  first_err_valid <= 1'b1;
                  first_err_idx   <= err_idx;
                  first_err_ofm   <= err_ofm;
                  first_err_gld   <= err_gld;
               end
            end
         end

         // An empty check (straight from IDLE) always passes.
         if (state_next == FINISH && state != FINISH)
            pass <= (state == IDLE) || (mismatch_count == '0);
      end
   end

endmodule

// File: tb/tb_ofm_stream_checker.sv
// Self-checking bench for ofm_stream_checker: RAM models with latency 1 and 3, a
// beat-level reference model, and a per-cycle compare of handshake and results.
module tb_ofm_stream_checker;

   localparam int DW = 64;
   localparam int LN = 16;
   localparam int CW = 24;
   localparam int AW = 22;
   localparam int GW = 8;
   localparam int BW = LN * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start1, start3;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] num_beats;
   logic          stop_on_first;

   logic          d1_en, d1_gen, d1_busy, d1_done, d1_pass, d1_fev;
   logic [AW-1:0] d1_addr;
   logic [GW-1:0] d1_gaddr;
   logic [CW-1:0] d1_cnt, d1_fidx;
   logic [DW-1:0] d1_fofm, d1_fgld;
   logic [BW-1:0] d1_odata, d1_gdata;

   logic          d3_en, d3_gen, d3_busy, d3_done, d3_pass, d3_fev;
   logic [AW-1:0] d3_addr;
   logic [GW-1:0] d3_gaddr;
   logic [CW-1:0] d3_cnt, d3_fidx;
   logic [DW-1:0] d3_fofm, d3_fgld;
   logic [BW-1:0] d3_odata, d3_gdata;

   logic          use3;
   logic          o_en, o_gen, o_busy, o_done, o_pass, o_fev;
   logic [AW-1:0] o_addr;
   logic [GW-1:0] o_gaddr;
   logic [CW-1:0] o_cnt, o_fidx;
   logic [DW-1:0] o_fofm, o_fgld;

   logic [BW-1:0] gld_mem [0:255];
   logic [BW-1:0] o1_pipe, g1_pipe;
   logic [BW-1:0] o3_pipe [0:2];
   logic [BW-1:0] g3_pipe [0:2];

   int checks = 0;
   int failures = 0;

   logic [AW-1:0] addr_log [$];
   int            cap_done_rel;
   logic [CW-1:0] cap_cnt, cap_idx;

   always #5 clk = ~clk;

   ofm_stream_checker #(.RD_LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .base_addr(base_addr),
      .num_beats(num_beats), .stop_on_first(stop_on_first),
      .ofm_rd_en(d1_en), .ofm_rd_addr(d1_addr), .ofm_rd_data(d1_odata),
      .gld_rd_en(d1_gen), .gld_rd_addr(d1_gaddr), .gld_rd_data(d1_gdata),
      .busy(d1_busy), .done(d1_done), .pass(d1_pass), .mismatch_count(d1_cnt),
      .first_err_valid(d1_fev), .first_err_idx(d1_fidx),
      .first_err_ofm(d1_fofm), .first_err_gld(d1_fgld));

   ofm_stream_checker #(.RD_LATENCY(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .base_addr(base_addr),
      .num_beats(num_beats), .stop_on_first(stop_on_first),
      .ofm_rd_en(d3_en), .ofm_rd_addr(d3_addr), .ofm_rd_data(d3_odata),
      .gld_rd_en(d3_gen), .gld_rd_addr(d3_gaddr), .gld_rd_data(d3_gdata),
      .busy(d3_busy), .done(d3_done), .pass(d3_pass), .mismatch_count(d3_cnt),
      .first_err_valid(d3_fev), .first_err_idx(d3_fidx),
      .first_err_ofm(d3_fofm), .first_err_gld(d3_fgld));

   function automatic logic [DW-1:0] ofm_word(input logic [AW-1:0] a, input int l);
      return {10'h0, a, 16'hC0DE, 8'(l), 8'h5A};
   endfunction

   function automatic logic [BW-1:0] beat_data(input logic [AW-1:0] a);
      logic [BW-1:0] r;
      for (int l = 0; l < LN; l++) r[l*DW +: DW] = ofm_word(a, l);
      return r;
   endfunction

   // OFM contents are a pure function of address; golden RAM is a table the tests edit.
   always @(posedge clk) begin
      if (d1_en) begin
         o1_pipe <= beat_data(d1_addr);
         g1_pipe <= gld_mem[d1_gaddr];
      end
   end

   always @(posedge clk) begin
      for (int i = 2; i > 0; i--) begin
         o3_pipe[i] <= o3_pipe[i-1];
         g3_pipe[i] <= g3_pipe[i-1];
      end
      if (d3_en) begin
         o3_pipe[0] <= beat_data(d3_addr);
         g3_pipe[0] <= gld_mem[d3_gaddr];
      end
   end

   assign d1_odata = o1_pipe;
   assign d1_gdata = g1_pipe;
   assign d3_odata = o3_pipe[2];
   assign d3_gdata = g3_pipe[2];

   always_comb begin
      o_en    = use3 ? d3_en    : d1_en;
      o_gen   = use3 ? d3_gen   : d1_gen;
      o_busy  = use3 ? d3_busy  : d1_busy;
      o_done  = use3 ? d3_done  : d1_done;
      o_pass  = use3 ? d3_pass  : d1_pass;
      o_fev   = use3 ? d3_fev   : d1_fev;
      o_addr  = use3 ? d3_addr  : d1_addr;
      o_gaddr = use3 ? d3_gaddr : d1_gaddr;
      o_cnt   = use3 ? d3_cnt   : d1_cnt;
      o_fidx  = use3 ? d3_fidx  : d1_fidx;
      o_fofm  = use3 ? d3_fofm  : d1_fofm;
      o_fgld  = use3 ? d3_fgld  : d1_fgld;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic set_golden(input logic [AW-1:0] base);
      for (int k = 0; k < 256; k++) gld_mem[k] = beat_data(base + AW'(k));
   endtask

   // Runs one check: model first, then a per-cycle compare from the cycle after start.
   task automatic applyStimulus(input bit sel3, input logic [AW-1:0] base, input int n,
                                input bit stop, input int glitch_rel);
      int            exp_cnt, abort_b, exp_last, exp_done_rel, rl;
      bit            exp_fev, miss, exp_en;
      logic [CW-1:0] exp_fidx;
      logic [DW-1:0] exp_fofm, exp_fgld, ow, gw;
      logic [BW-1:0] gbeat;
      logic [AW-1:0] ea;

      exp_cnt = 0; exp_fev = 0; exp_fidx = '0; exp_fofm = '0; exp_fgld = '0; abort_b = -1;
      for (int b = 0; b < n; b++) begin
         miss  = 0;
         gbeat = gld_mem[b % 256];
         for (int l = 0; l < LN; l++) begin
            ow = ofm_word(base + AW'(b), l);
            gw = gbeat[l*DW +: DW];
            if (ow !== gw) begin
               exp_cnt++;
               miss = 1;
               if (!exp_fev) begin
                  exp_fev = 1; exp_fidx = CW'(b * LN + l); exp_fofm = ow; exp_fgld = gw;
               end
            end
         end
         if (stop && miss) begin
            abort_b = b;
            break;
         end
      end
      rl = sel3 ? 3 : 1;
      if (n == 0) begin
         exp_last = -1; exp_done_rel = 0;
      end else if (abort_b >= 0) begin
         exp_last = (abort_b + rl < n - 1) ? abort_b + rl : n - 1;
         exp_done_rel = abort_b + rl + 2;
      end else begin
         exp_last = n - 1; exp_done_rel = n + rl + 1;
      end

      use3 = sel3;
      addr_log.delete();
      cap_done_rel = -1;
      @(negedge clk);
      base_addr = base; num_beats = CW'(n); stop_on_first = stop;
      if (sel3) start3 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      for (int rel = 0; rel <= exp_done_rel + 2; rel++) begin
         if (rel > 0) @(negedge clk);
         start1 = 1'b0; start3 = 1'b0;
         if (rel == glitch_rel) begin
            base_addr = ~base; num_beats = CW'(3); stop_on_first = !stop;
            if (sel3) start3 = 1'b1; else start1 = 1'b1;
         end
         exp_en = (rel <= exp_last);
         if (o_en) addr_log.push_back(o_addr);
         if (o_done) cap_done_rel = rel;
         checkOutput($sformatf("ctrl@%0d", rel), {o_en, o_gen, o_busy, o_done},
                     {exp_en, exp_en, rel < exp_done_rel, rel == exp_done_rel});
         if (exp_en) begin
            ea = base + AW'(rel);
            checkOutput($sformatf("ofm_addr@%0d", rel), o_addr, ea);
            checkOutput($sformatf("gld_addr@%0d", rel), o_gaddr, GW'(rel));
         end
         if (rel == exp_done_rel) begin
            cap_cnt = o_cnt; cap_idx = o_fidx;
            checkOutput("pass", o_pass, exp_cnt == 0);
            checkOutput("mismatch_count", o_cnt, CW'(exp_cnt));
            checkOutput("first_err_valid", o_fev, exp_fev);
            checkOutput("first_err_idx", o_fidx, exp_fidx);
            checkOutput("first_err_ofm", o_fofm, exp_fofm);
            checkOutput("first_err_gld", o_fgld, exp_fgld);
         end
      end
   endtask

   initial begin
      int            cnt_bad;
      logic [AW-1:0] wrap_exp [4];
      rst = 1'b1; start1 = 1'b0; start3 = 1'b0; use3 = 1'b0;
      base_addr = '0; num_beats = '0; stop_on_first = 1'b0;
      set_golden('0);
      repeat (3) @(negedge clk);
      checkOutput("reset_dut1", |{d1_en, d1_gen, d1_addr, d1_gaddr, d1_busy, d1_done, d1_pass,
                  d1_cnt, d1_fev, d1_fidx, d1_fofm, d1_fgld}, 0);
      checkOutput("reset_dut3", |{d3_en, d3_gen, d3_addr, d3_gaddr, d3_busy, d3_done, d3_pass,
                  d3_cnt, d3_fev, d3_fidx, d3_fofm, d3_fgld}, 0);
      rst = 1'b0;

      $display("[TB] matching window, N=9");
      set_golden(22'd253776);
      applyStimulus(0, 22'd253776, 9, 0, -1);
      checkOutput("t1_done_rel", cap_done_rel, 11);

      $display("[TB] beat 3 lanes 5 and 9 corrupted, no abort");
      gld_mem[3][5*DW +: DW] = gld_mem[3][5*DW +: DW] ^ 64'hDEAD_0000_0000_BEEF;
      gld_mem[3][9*DW +: DW] = gld_mem[3][9*DW +: DW] ^ 64'h0000_0001_0000_0000;
      applyStimulus(0, 22'd253776, 9, 0, -1);
      checkOutput("t2_count", cap_cnt, 2);
      checkOutput("t2_idx", cap_idx, 53);
      checkOutput("t2_done_rel", cap_done_rel, 11);

      $display("[TB] same corruption, stop on first");
      applyStimulus(0, 22'd253776, 9, 1, -1);
      checkOutput("t3_count", cap_cnt, 2);
      checkOutput("t3_done_rel", cap_done_rel, 6);
      checkOutput("t3_last_issue", addr_log.size(), 5);

      $display("[TB] empty window");
      applyStimulus(0, 22'd5, 0, 0, -1);
      checkOutput("t4_done_rel", cap_done_rel, 0);

      $display("[TB] address wrap with start while busy");
      set_golden(22'h3FFFFE);
      applyStimulus(0, 22'h3FFFFE, 4, 0, 2);
      wrap_exp = '{22'h3FFFFE, 22'h3FFFFF, 22'h000000, 22'h000001};
      checkOutput("wrap_len", addr_log.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < addr_log.size()) checkOutput($sformatf("wrap_addr%0d", i), addr_log[i], wrap_exp[i]);

      $display("[TB] reset in the middle of a check");
      set_golden(22'd100);
      use3 = 1'b0;
      @(negedge clk);
      base_addr = 22'd100; num_beats = CW'(9); stop_on_first = 1'b0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid", |{d1_en, d1_gen, d1_addr, d1_gaddr, d1_busy, d1_done, d1_pass,
                  d1_cnt, d1_fev, d1_fidx, d1_fofm, d1_fgld}, 0);
      rst = 1'b0;
      cnt_bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (d1_done || d1_busy) cnt_bad++;
      end
      checkOutput("rst_no_done", cnt_bad, 0);

      $display("[TB] latency 3, matching window, N=5");
      applyStimulus(1, 22'd100, 5, 0, -1);
      checkOutput("t7_done_rel", cap_done_rel, 9);

      $display("[TB] latency 3, beat 1 lane 0 corrupted, stop on first");
      gld_mem[1][0 +: DW] = gld_mem[1][0 +: DW] ^ 64'h1;
      applyStimulus(1, 22'd100, 5, 1, -1);
      checkOutput("t8_idx", cap_idx, 16);
      checkOutput("t8_count", cap_cnt, 1);
      checkOutput("t8_done_rel", cap_done_rel, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
